// File: rtl/mem_test_ram_responder.sv
// Single-port memory responder for the memory tester: accepts one write or
// read request at a time, completes it after a fixed latency and reports the
// completion with a one-cycle registered pulse. An optional fault injector
// XORs a mask into read data returned for one chosen address.
module mem_test_ram_responder #(
    parameter int DATUM_WIDTH   = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int WRITE_LATENCY = 1,
    parameter int READ_LATENCY  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n_async,
    input  logic                   i_wr_req,
    input  logic                   i_rd_req,
    input  logic [ADDR_WIDTH-1:0]  i_address,
    input  logic [DATUM_WIDTH-1:0] i_memory_data_write,
    input  logic                   i_fault_ena,
    input  logic [ADDR_WIDTH-1:0]  i_fault_addr,
    input  logic [DATUM_WIDTH-1:0] i_fault_mask,
    output logic                   o_memory_write_ready,
    output logic                   o_memory_read_valid,
    output logic [DATUM_WIDTH-1:0] o_memory_data_read,
    output logic                   o_busy
);

    localparam int MAX_LAT = (WRITE_LATENCY > READ_LATENCY) ? WRITE_LATENCY : READ_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   is_wr_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [DATUM_WIDTH-1:0] wdata_r;
    logic                   fault_ena_r;
    logic [ADDR_WIDTH-1:0]  fault_addr_r;
    logic [DATUM_WIDTH-1:0] fault_mask_r;
    logic                   write_ready_r;
    logic                   read_valid_r;
    logic [DATUM_WIDTH-1:0] data_read_r;
    logic                   busy_r;

    logic [DATUM_WIDTH-1:0] mem_r [0:DEPTH-1];

    logic                   accept_s;
    logic                   enter_resp_s;
    logic                   op_wr_s;
    logic [ADDR_WIDTH-1:0]  op_addr_s;
    logic [DATUM_WIDTH-1:0] op_wdata_s;
    logic                   op_fault_s;
    logic [DATUM_WIDTH-1:0] op_mask_s;
    logic [DATUM_WIDTH-1:0] rd_word_s;
    logic                   commit_s;

    // Select the operation being completed: live inputs in IDLE (single-edge
    // latency completes at the acceptance edge), latched copies otherwise.
    always_comb begin
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        op_wr_s      = is_wr_r;
        op_addr_s    = addr_r;
        op_wdata_s   = wdata_r;
        op_fault_s   = fault_ena_r && (addr_r == fault_addr_r);
        op_mask_s    = fault_mask_r;
        case (state_r)
            ST_IDLE: begin
                accept_s   = i_wr_req || i_rd_req;
                op_wr_s    = i_wr_req;
                op_addr_s  = i_address;
                op_wdata_s = i_memory_data_write;
                op_fault_s = i_fault_ena && (i_address == i_fault_addr);
                op_mask_s  = i_fault_mask;
                if (i_wr_req) begin
                    enter_resp_s = accept_s && (WRITE_LATENCY == 1);
                end else begin
                    enter_resp_s = accept_s && (READ_LATENCY == 1);
                end
            end
            ST_WAIT: begin
                enter_resp_s = (cnt_r == CNT_ONE);
            end
            ST_RESP: begin
                enter_resp_s = 1'b0;
            end
            default: begin
                enter_resp_s = 1'b0;
            end
        endcase
        commit_s = enter_resp_s && op_wr_s;
        if (op_fault_s) begin
            rd_word_s = mem_r[op_addr_s] ^ op_mask_s;
        end else begin
            rd_word_s = mem_r[op_addr_s];
        end
    end

    // Storage array: written only on the edge that enters RESP for a write.
    always_ff @(posedge i_clk) begin
        if (commit_s) begin
            mem_r[op_addr_s] <= op_wdata_s;
        end
    end

    // Request FSM with latency counter and registered completion outputs.
    always_ff @(posedge i_clk or negedge i_rst_n_async) begin
        if (!i_rst_n_async) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            is_wr_r       <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= '0;
            fault_ena_r   <= 1'b0;
            fault_addr_r  <= '0;
            fault_mask_r  <= '0;
            write_ready_r <= 1'b0;
            read_valid_r  <= 1'b0;
            data_read_r   <= '0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        is_wr_r      <= i_wr_req;
                        addr_r       <= i_address;
                        wdata_r      <= i_memory_data_write;
                        fault_ena_r  <= i_fault_ena;
                        fault_addr_r <= i_fault_addr;
                        fault_mask_r <= i_fault_mask;
                        busy_r       <= 1'b1;
                        if (enter_resp_s) begin
                            state_r <= ST_RESP;
                            cnt_r   <= '0;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= i_wr_req ? WR_LOAD : RD_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (enter_resp_s) begin
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_r       <= ST_IDLE;
                    write_ready_r <= 1'b0;
                    read_valid_r  <= 1'b0;
                    busy_r        <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cnt_r         <= '0;
                    write_ready_r <= 1'b0;
                    read_valid_r  <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
            if (enter_resp_s) begin
                if (op_wr_s) begin
                    write_ready_r <= 1'b1;
                end else begin
                    read_valid_r <= 1'b1;
                    data_read_r  <= rd_word_s;
                end
            end
        end
    end

    assign o_memory_write_ready = write_ready_r;
    assign o_memory_read_valid  = read_valid_r;
    assign o_memory_data_read   = data_read_r;
    assign o_busy               = busy_r;

endmodule

// File: tb/tb_mem_test_ram_responder.sv
// Directed bench for mem_test_ram_responder. Instance a uses default
// latencies; instance b uses WRITE_LATENCY=3 and has its own reset so a write
// can be interrupted mid-flight. Both see the same request traffic.
module tb_mem_test_ram_responder;

    logic       clk = 1'b0;
    logic       rst_n_a = 1'b1;
    logic       rst_n_b = 1'b1;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       fault_ena = 1'b0;
    logic [7:0] fault_addr = 8'h00;
    logic [7:0] fault_mask = 8'h00;

    logic       a_wready, a_rvalid, a_busy;
    logic [7:0] a_rdata;
    logic       b_wready, b_rvalid, b_busy;
    logic [7:0] b_rdata;

    int checks = 0;
    int errors = 0;
    int a_wr_cnt = 0, a_rd_cnt = 0, b_wr_cnt = 0, b_rd_cnt = 0;
    int s_awr, s_ard, s_bwr;

    always #5 clk = ~clk;

    mem_test_ram_responder dut_a (
        .i_clk(clk), .i_rst_n_async(rst_n_a),
        .i_wr_req(wr_req), .i_rd_req(rd_req),
        .i_address(address), .i_memory_data_write(wdata),
        .i_fault_ena(fault_ena), .i_fault_addr(fault_addr), .i_fault_mask(fault_mask),
        .o_memory_write_ready(a_wready), .o_memory_read_valid(a_rvalid),
        .o_memory_data_read(a_rdata), .o_busy(a_busy)
    );

    mem_test_ram_responder #(.WRITE_LATENCY(3)) dut_b (
        .i_clk(clk), .i_rst_n_async(rst_n_b),
        .i_wr_req(wr_req), .i_rd_req(rd_req),
        .i_address(address), .i_memory_data_write(wdata),
        .i_fault_ena(fault_ena), .i_fault_addr(fault_addr), .i_fault_mask(fault_mask),
        .o_memory_write_ready(b_wready), .o_memory_read_valid(b_rvalid),
        .o_memory_data_read(b_rdata), .o_busy(b_busy)
    );

    // Pulse counters, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (a_wready) a_wr_cnt++;
        if (a_rvalid) a_rd_cnt++;
        if (b_wready) b_wr_cnt++;
        if (b_rvalid) b_rd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (5) tick();
    endtask

    // One request accepted at the next edge, then both instances drain.
    task automatic request(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        wr_req = w; rd_req = r; address = a; wdata = d;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        settle();
    endtask

    initial begin
        // Reset asserted mid-cycle, released away from an edge.
        #2;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        repeat (2) tick();
        #2;
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        tick();
        chk("rst_wready", a_wready, 32'd0);
        chk("rst_rvalid", a_rvalid, 32'd0);
        chk("rst_rdata",  a_rdata,  32'd0);
        chk("rst_busy",   a_busy,   32'd0);
        chk("rst_b_busy", b_busy,   32'd0);

        // Write 0xA5 to 0x10: instance a completes after one edge.
        wr_req = 1'b1; address = 8'h10; wdata = 8'hA5;
        tick();
        wr_req = 1'b0;
        chk("wr_pulse",      a_wready, 32'd1);
        chk("wr_busy",       a_busy,   32'd1);
        chk("wr_b_noyet",    b_wready, 32'd0);
        tick();
        chk("wr_pulse_end",  a_wready, 32'd0);
        chk("wr_idle",       a_busy,   32'd0);
        chk("wr_b_busy",     b_busy,   32'd1);
        tick();
        chk("wr_b_pulse",    b_wready, 32'd1);
        tick();
        chk("wr_b_idle",     b_busy,   32'd0);

        // Read 0x10: valid after two edges, data aligned with the pulse.
        rd_req = 1'b1; address = 8'h10;
        tick();
        rd_req = 1'b0;
        chk("rd_busy",       a_busy,   32'd1);
        chk("rd_noyet",      a_rvalid, 32'd0);
        tick();
        chk("rd_pulse",      a_rvalid, 32'd1);
        chk("rd_data",       a_rdata,  32'h0000_00A5);
        chk("rd_b_data",     b_rdata,  32'h0000_00A5);
        tick();
        chk("rd_pulse_end",  a_rvalid, 32'd0);
        chk("rd_idle",       a_busy,   32'd0);
        chk("rd_data_hold",  a_rdata,  32'h0000_00A5);
        settle();

        // Simultaneous requests: write wins, read dropped.
        s_awr = a_wr_cnt; s_ard = a_rd_cnt;
        request(1'b1, 1'b1, 8'h20, 8'h3C);
        chk("sim_wr_cnt", a_wr_cnt - s_awr, 32'd1);
        chk("sim_rd_cnt", a_rd_cnt - s_ard, 32'd0);
        request(1'b0, 1'b1, 8'h20, 8'h00);
        chk("sim_rd_back", a_rdata, 32'h0000_003C);

        // Write attempted while a read is in WAIT is ignored.
        s_awr = a_wr_cnt; s_ard = a_rd_cnt;
        rd_req = 1'b1; address = 8'h10;
        tick();
        rd_req = 1'b0; wr_req = 1'b1; wdata = 8'hFF;
        tick();
        wr_req = 1'b0;
        settle();
        chk("busy_rd_cnt", a_rd_cnt - s_ard, 32'd1);
        chk("busy_wr_cnt", a_wr_cnt - s_awr, 32'd0);
        request(1'b0, 1'b1, 8'h10, 8'h00);
        chk("busy_rd_back", a_rdata, 32'h0000_00A5);

        // Fault injection on 0x10 only; array untouched.
        fault_ena = 1'b1; fault_addr = 8'h10; fault_mask = 8'h01;
        request(1'b0, 1'b1, 8'h10, 8'h00);
        chk("fault_hit",   a_rdata, 32'h0000_00A4);
        request(1'b0, 1'b1, 8'h20, 8'h00);
        chk("fault_miss",  a_rdata, 32'h0000_003C);
        fault_ena = 1'b0;
        request(1'b0, 1'b1, 8'h10, 8'h00);
        chk("fault_off",   a_rdata, 32'h0000_00A5);

        // Reset of instance b during a 3-edge write: no pulse, no commit.
        request(1'b1, 1'b0, 8'h30, 8'h5A);
        s_bwr = b_wr_cnt;
        wr_req = 1'b1; address = 8'h30; wdata = 8'h77;
        tick();
        wr_req = 1'b0;
        tick();
        chk("rstw_b_busy", b_busy, 32'd1);
        rst_n_b = 1'b0;
        #1;
        chk("rstw_b_idle", b_busy, 32'd0);
        tick();
        #2;
        rst_n_b = 1'b1;
        settle();
        chk("rstw_b_nopulse", b_wr_cnt - s_bwr, 32'd0);
        request(1'b0, 1'b1, 8'h30, 8'h00);
        chk("rstw_b_keep", b_rdata, 32'h0000_005A);
        chk("rstw_a_new",  a_rdata, 32'h0000_0077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
